ctrl_word_encoder: RTL and testbench

- Encoding side of the 16-bit packed control word consumed by the datapath control-signal unpacker.
- Decodes the RV32I instruction presented in the decode (D) stage and produces the packed word.
- Registers the word into the X and M/W pipeline stages, handling stall bubbles and flush kills.
- Flags load-use hazards and illegal opcodes.

---
 rtl/ctrl_pkg.sv | 102 ++++++++++
 rtl/ctrl_word_decode_comb.sv | 162 ++++++++++++++++
 rtl/ctrl_word_encoder.sv | 103 ++++++++++
 tb/tb_ctrl_word_encoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings and field layout of the 16-bit packed control word
package ctrl_pkg;

  localparam int CW_W = 16;
  localparam logic [CW_W-1:0] NOP_CW = 16'h0000;

  // RV32I major opcodes understood by the encoder
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_sel_e;

  typedef enum logic [1:0] {
    WB_MEM = 2'd0,
    WB_ALU = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  // PC_RSVD exists so the unpacker can name it; the encoder never emits it
  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_JUMP   = 2'd1,
    PC_BRANCH = 2'd2,
    PC_RSVD   = 2'd3
  } pc_sel_e;

  // Field order is MSB first so the struct overlays the packed word bit for bit
  typedef struct packed {
    pc_sel_e  pc_sel;   // [15:14]
    wb_sel_e  wb_sel;   // [13:12]
    logic     mem_rw;   // [11]
    alu_sel_e alu_sel;  // [10:7]
    logic     b_sel;    // [6]
    logic     a_sel;    // [5]
    logic     br_lun;   // [4]
    imm_sel_e imm_sel;  // [3:1]
    logic     reg_wen;  // [0]
  } ctrl_word_t;

  localparam int CW_REG_WEN    = 0;
  localparam int CW_IMM_SEL_LO = 1;
  localparam int CW_IMM_SEL_HI = 3;
  localparam int CW_BR_LUN     = 4;
  localparam int CW_A_SEL      = 5;
  localparam int CW_B_SEL      = 6;
  localparam int CW_ALU_SEL_LO = 7;
  localparam int CW_ALU_SEL_HI = 10;
  localparam int CW_MEM_RW     = 11;
  localparam int CW_WB_SEL_LO  = 12;
  localparam int CW_WB_SEL_HI  = 13;
  localparam int CW_PC_SEL_LO  = 14;
  localparam int CW_PC_SEL_HI  = 15;

  // ALU operation for R-type and I-type arithmetic; alt selects SUB/SRA
  function automatic alu_sel_e alu_from_funct(input logic [2:0] funct3, input logic alt);
    alu_sel_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_word_decode_comb.sv
// rtl/ctrl_word_decode_comb.sv - combinational RV32I instruction to packed control word decoder
module ctrl_word_decode_comb
  import ctrl_pkg::*;
#(
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic [31:0] inst,
  output logic [15:0] cw,
  output logic        illegal,
  output logic        csr_we,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  ctrl_word_t w;
  logic       legal;
  logic       is_csr;
  logic       rd_rs1;
  logic       rd_rs2;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  // Per-opcode field selection plus legality of funct3/funct7 combinations
  always_comb begin
    w      = '0;
    legal  = 1'b1;
    is_csr = 1'b0;
    rd_rs1 = 1'b1;
    rd_rs2 = 1'b0;
    case (opcode)
      OP_REG: begin
        w.reg_wen = 1'b1;
        w.wb_sel  = WB_ALU;
        w.alu_sel = alu_from_funct(funct3, funct7[5]);
        rd_rs2    = 1'b1;
        if (funct7 == F7_ALT) begin
          legal = (funct3 == 3'b000) || (funct3 == 3'b101);
        end else begin
          legal = (funct7 == 7'b0000000);
        end
      end
      OP_IMM: begin
        w.reg_wen = 1'b1;
        w.b_sel   = 1'b1;
        w.wb_sel  = WB_ALU;
        // only the right shift reads funct7[5]; ADDI's imm bit 10 must not turn it into SUB
        w.alu_sel = alu_from_funct(funct3, (funct3 == 3'b101) && funct7[5]);
        if (funct3 == 3'b001) begin
          legal = (funct7 == 7'b0000000);
        end else if (funct3 == 3'b101) begin
          legal = (funct7 == 7'b0000000) || (funct7 == F7_ALT);
        end
      end
      OP_LOAD: begin
        w.reg_wen = 1'b1;
        w.imm_sel = IMM_I;
        w.b_sel   = 1'b1;
        w.alu_sel = ALU_ADD;
        w.wb_sel  = WB_MEM;
        // LBU/LHU zero-extend; the BrLUn bit is reused to carry that
        w.br_lun  = (funct3 == 3'b100) || (funct3 == 3'b101);
        legal     = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      OP_STORE: begin
        w.imm_sel = IMM_S;
        w.b_sel   = 1'b1;
        w.alu_sel = ALU_ADD;
        w.mem_rw  = 1'b1;
        rd_rs2    = 1'b1;
        legal     = !funct3[2] && (funct3 != 3'b011);
      end
      OP_BRANCH: begin
        w.imm_sel = IMM_B;
        w.a_sel   = 1'b1;
        w.b_sel   = 1'b1;
        w.alu_sel = ALU_ADD;
        w.pc_sel  = PC_BRANCH;
        w.br_lun  = (funct3 == 3'b110) || (funct3 == 3'b111);
        rd_rs2    = 1'b1;
        legal     = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OP_LUI: begin
        w.reg_wen = 1'b1;
        w.imm_sel = IMM_U;
        w.b_sel   = 1'b1;
        w.alu_sel = ALU_PASSB;
        w.wb_sel  = WB_ALU;
        rd_rs1    = 1'b0;
      end
      OP_AUIPC: begin
        w.reg_wen = 1'b1;
        w.imm_sel = IMM_U;
        w.a_sel   = 1'b1;
        w.b_sel   = 1'b1;
        w.alu_sel = ALU_ADD;
        w.wb_sel  = WB_ALU;
        rd_rs1    = 1'b0;
      end
      OP_JAL: begin
        w.reg_wen = 1'b1;
        w.imm_sel = IMM_J;
        w.a_sel   = 1'b1;
        w.b_sel   = 1'b1;
        w.alu_sel = ALU_ADD;
        w.wb_sel  = WB_PC4;
        w.pc_sel  = PC_JUMP;
        rd_rs1    = 1'b0;
      end
      OP_JALR: begin
        w.reg_wen = 1'b1;
        w.imm_sel = IMM_I;
        w.b_sel   = 1'b1;
        w.alu_sel = ALU_ADD;
        w.wb_sel  = WB_PC4;
        w.pc_sel  = PC_JUMP;
        legal     = (funct3 == 3'b000);
      end
      OP_SYSTEM: begin
        // only the CSR swap forms are supported; the CSR unit does the work,
        // so the datapath word stays a NOP
        is_csr = (funct3 == F3_CSRRW) || (funct3 == F3_CSRRWI);
        legal  = is_csr;
        rd_rs1 = (funct3 == F3_CSRRW);
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // Final word: NOP for illegal and CSR instructions, x0 destination never writes
  always_comb begin
    cw       = NOP_WORD;
    illegal  = 1'b0;
    csr_we   = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    if (!legal) begin
      illegal = 1'b1;
    end else if (is_csr) begin
      csr_we   = 1'b1;
      uses_rs1 = rd_rs1;
    end else begin
      cw               = w;
      cw[CW_REG_WEN]   = w.reg_wen && (rd != 5'd0);
      uses_rs1         = rd_rs1;
      uses_rs2         = rd_rs2;
    end
  end

endmodule

// File: rtl/ctrl_word_encoder.sv
// rtl/ctrl_word_encoder.sv - D-stage control word encoder with X and M/W pipeline registers
module ctrl_word_encoder #(
  parameter int              CW_W   = 16,
  parameter logic [CW_W-1:0] NOP_CW = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst_d,
  input  logic            valid_d,
  input  logic            stall,
  input  logic            flush,
  output logic [CW_W-1:0] ctrl_x,
  output logic [4:0]      rd_x,
  output logic [2:0]      funct3_x,
  output logic            valid_x,
  output logic            illegal_x,
  output logic            csr_we_x,
  output logic [CW_W-1:0] ctrl_m,
  output logic [4:0]      rd_m,
  output logic            valid_m,
  output logic            load_use
);

  import ctrl_pkg::*;

  logic [CW_W-1:0] cw_d;
  logic            illegal_d;
  logic            csr_we_d;
  logic            uses_rs1_d;
  logic            uses_rs2_d;
  logic [4:0]      rd_d;
  logic [4:0]      rs1_d;
  logic [4:0]      rs2_d;
  logic [2:0]      funct3_d;
  logic            bubble;
  logic            load_in_x;

  ctrl_word_decode_comb #(
    .NOP_WORD (NOP_CW)
  ) u_decode (
    .inst     (inst_d),
    .cw       (cw_d),
    .illegal  (illegal_d),
    .csr_we   (csr_we_d),
    .uses_rs1 (uses_rs1_d),
    .uses_rs2 (uses_rs2_d),
    .rd       (rd_d),
    .rs1      (rs1_d),
    .rs2      (rs2_d),
    .funct3   (funct3_d)
  );

  // stall and flush both turn the X slot into a bubble; together they are no different
  assign bubble = flush || stall || !valid_d;

  // X stage register: bubble on stall/flush/invalid, else the decoded D instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_x    <= '0;
      rd_x      <= '0;
      funct3_x  <= '0;
      valid_x   <= 1'b0;
      illegal_x <= 1'b0;
      csr_we_x  <= 1'b0;
    end else if (bubble) begin
      ctrl_x    <= NOP_CW;
      rd_x      <= '0;
      funct3_x  <= '0;
      valid_x   <= 1'b0;
      illegal_x <= 1'b0;
      csr_we_x  <= 1'b0;
    end else begin
      ctrl_x    <= cw_d;
      rd_x      <= rd_d;
      funct3_x  <= funct3_d;
      valid_x   <= 1'b1;
      illegal_x <= illegal_d;
      csr_we_x  <= csr_we_d;
    end
  end

  // M/W stage register: always advances from X, stall and flush act only on D->X
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_m  <= '0;
      rd_m    <= '0;
      valid_m <= 1'b0;
    end else begin
      ctrl_m  <= ctrl_x;
      rd_m    <= rd_x;
      valid_m <= valid_x;
    end
  end

  // a load in X whose result is not ready for the instruction now sitting in D
  assign load_in_x = valid_x && ctrl_x[CW_REG_WEN]
                  && (ctrl_x[CW_WB_SEL_HI:CW_WB_SEL_LO] == WB_MEM)
                  && (rd_x != 5'd0);

  assign load_use = load_in_x && valid_d
                 && ((uses_rs1_d && (rs1_d == rd_x)) || (uses_rs2_d && (rs2_d == rd_x)));

endmodule

// File: tb/tb_ctrl_word_encoder.sv
// tb/tb_ctrl_word_encoder.sv - directed self-checking bench for ctrl_word_encoder
module tb_ctrl_word_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_d;
  logic        valid_d;
  logic        stall;
  logic        flush;
  logic [15:0] ctrl_x;
  logic [4:0]  rd_x;
  logic [2:0]  funct3_x;
  logic        valid_x;
  logic        illegal_x;
  logic        csr_we_x;
  logic [15:0] ctrl_m;
  logic [4:0]  rd_m;
  logic        valid_m;
  logic        load_use;

  int n_checks = 0;
  int n_errors = 0;

  ctrl_word_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .inst_d    (inst_d),
    .valid_d   (valid_d),
    .stall     (stall),
    .flush     (flush),
    .ctrl_x    (ctrl_x),
    .rd_x      (rd_x),
    .funct3_x  (funct3_x),
    .valid_x   (valid_x),
    .illegal_x (illegal_x),
    .csr_we_x  (csr_we_x),
    .ctrl_m    (ctrl_m),
    .rd_m      (rd_m),
    .valid_m   (valid_m),
    .load_use  (load_use)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic v, input logic s, input logic f);
    inst_d  = i;
    valid_d = v;
    stall   = s;
    flush   = f;
  endtask

  localparam logic [31:0] I_ADD     = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_SUB     = 32'h402081B3; // sub  x3,x1,x2
  localparam logic [31:0] I_LW_X5   = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] I_LW_X0   = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] I_ADD_RS5 = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] I_ADD_RS0 = 32'h00200333; // add  x6,x0,x2
  localparam logic [31:0] I_ADD_X5  = 32'h002082B3; // add  x5,x1,x2
  localparam logic [31:0] I_SW_RS5  = 32'h0050A023; // sw   x5,0(x1)
  localparam logic [31:0] I_LUI_X9  = 32'h000284B7; // lui  x9 with rs1 field = 5
  localparam logic [31:0] I_LUI_X7  = 32'h123453B7; // lui  x7,0x12345
  localparam logic [31:0] I_MUL     = 32'h022081B3; // funct7=1: not RV32I
  localparam logic [31:0] I_ADDI_X0 = 32'h00100013; // addi x0,x0,1
  localparam logic [31:0] I_CSRRW   = 32'h51E09073; // csrrw x0,0x51e,x1

  // opcode sweep with hand-packed control words
  logic [31:0] sw_inst [9] = '{
    32'h402081B3, // sub   x3,x1,x2
    32'h4030D213, // srai  x4,x1,3
    32'h0040C283, // lbu   x5,4(x1)
    32'h0020A423, // sw    x2,8(x1)
    32'h0020E463, // bltu  x1,x2,+8
    32'h123453B7, // lui   x7,0x12345
    32'h00001417, // auipc x8,1
    32'h010000EF, // jal   x1,+16
    32'h000280E7  // jalr  x1,0(x5)
  };
  logic [15:0] sw_cw [9] = '{
    16'h1081, 16'h13C1, 16'h0051, 16'h0842, 16'h8074,
    16'h1547, 16'h1067, 16'h6069, 16'h6041
  };
  logic [4:0] sw_rd [9] = '{5'd3, 5'd4, 5'd5, 5'd8, 5'd8, 5'd7, 5'd8, 5'd1, 5'd1};
  string sw_name [9] = '{"sub", "srai", "lbu", "sw", "bltu", "lui", "auipc", "jal", "jalr"};

  initial begin
    rst = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    #12;
    check("rst_ctrl_x", ctrl_x, 16'h0000);
    check("rst_ctrl_m", ctrl_m, 16'h0000);
    check("rst_valid_x", valid_x, 0);
    check("rst_valid_m", valid_m, 0);
    check("rst_illegal_x", illegal_x, 0);
    check("rst_csr_we_x", csr_we_x, 0);
    check("rst_load_use", load_use, 0);
    rst = 1'b0;

    drive(I_ADD, 1'b1, 1'b0, 1'b0);
    step();
    check("add_ctrl_x", ctrl_x, 16'h1001);
    check("add_rd_x", rd_x, 3);
    check("add_valid_x", valid_x, 1);
    step();
    check("add_ctrl_m", ctrl_m, 16'h1001);
    check("add_rd_m", rd_m, 3);
    check("add_valid_m", valid_m, 1);

    for (int i = 0; i < 9; i++) begin
      logic [31:0] cur;
      cur = sw_inst[i];
      drive(cur, 1'b1, 1'b0, 1'b0);
      step();
      check({sw_name[i], "_ctrl_x"}, ctrl_x, sw_cw[i]);
      check({sw_name[i], "_rd_x"}, rd_x, sw_rd[i]);
      check({sw_name[i], "_funct3_x"}, funct3_x, cur[14:12]);
      check({sw_name[i], "_illegal_x"}, illegal_x, 0);
    end

    drive(I_LW_X5, 1'b1, 1'b0, 1'b0);
    step();
    check("lw_ctrl_x", ctrl_x, 16'h0041);
    drive(I_ADD_RS5, 1'b1, 1'b0, 1'b0);
    #1 check("lu_rs1", load_use, 1);
    drive(I_SW_RS5, 1'b1, 1'b0, 1'b0);
    #1 check("lu_rs2_store", load_use, 1);
    drive(I_LUI_X9, 1'b1, 1'b0, 1'b0);
    #1 check("lu_lui", load_use, 0);
    drive(I_ADD_RS5, 1'b0, 1'b0, 1'b0);
    #1 check("lu_d_invalid", load_use, 0);
    drive(I_LW_X0, 1'b1, 1'b0, 1'b0);
    step();
    drive(I_ADD_RS0, 1'b1, 1'b0, 1'b0);
    #1 check("lu_rd_x0", load_use, 0);
    drive(I_ADD_X5, 1'b1, 1'b0, 1'b0);
    step();
    drive(I_ADD_RS5, 1'b1, 1'b0, 1'b0);
    #1 check("lu_alu_in_x", load_use, 0);

    drive(I_SUB, 1'b1, 1'b0, 1'b0);
    step();
    drive(I_ADD, 1'b1, 1'b1, 1'b0);
    step();
    check("stall1_ctrl_x", ctrl_x, 16'h0000);
    check("stall1_valid_x", valid_x, 0);
    check("stall1_ctrl_m", ctrl_m, 16'h1081);
    check("stall1_valid_m", valid_m, 1);
    step();
    check("stall2_ctrl_x", ctrl_x, 16'h0000);
    check("stall2_valid_x", valid_x, 0);
    check("stall2_ctrl_m", ctrl_m, 16'h0000);
    check("stall2_valid_m", valid_m, 0);
    drive(I_ADD, 1'b1, 1'b0, 1'b0);
    step();
    check("resume_ctrl_x", ctrl_x, 16'h1001);
    drive(I_ADD, 1'b1, 1'b1, 1'b1);
    step();
    check("stflush_ctrl_x", ctrl_x, 16'h0000);
    check("stflush_valid_x", valid_x, 0);
    check("stflush_rd_x", rd_x, 0);
    check("stflush_ctrl_m", ctrl_m, 16'h1001);
    drive(I_ADD, 1'b1, 1'b0, 1'b1);
    step();
    check("flush_valid_x", valid_x, 0);
    drive(I_ADD, 1'b0, 1'b0, 1'b0);
    step();
    check("invalid_valid_x", valid_x, 0);
    check("invalid_ctrl_x", ctrl_x, 16'h0000);

    drive(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    step();
    check("ones_illegal_x", illegal_x, 1);
    check("ones_ctrl_x", ctrl_x, 16'h0000);
    drive(I_MUL, 1'b1, 1'b0, 1'b0);
    step();
    check("mul_illegal_x", illegal_x, 1);
    check("mul_ctrl_x", ctrl_x, 16'h0000);
    drive(I_ADDI_X0, 1'b1, 1'b0, 1'b0);
    step();
    check("addi_x0_ctrl_x", ctrl_x, 16'h1040);
    check("addi_x0_regwen", ctrl_x[0], 0);
    check("addi_x0_illegal", illegal_x, 0);
    drive(I_CSRRW, 1'b1, 1'b0, 1'b0);
    step();
    check("csrrw_csr_we_x", csr_we_x, 1);
    check("csrrw_ctrl_x", ctrl_x, 16'h0000);
    check("csrrw_illegal_x", illegal_x, 0);

    drive(I_ADD, 1'b1, 1'b0, 1'b0);
    step();
    step();
    check("pre_rst_ctrl_x", ctrl_x, 16'h1001);
    check("pre_rst_ctrl_m", ctrl_m, 16'h1001);
    rst = 1'b1;
    #1;
    check("async_ctrl_x", ctrl_x, 16'h0000);
    check("async_ctrl_m", ctrl_m, 16'h0000);
    check("async_valid_x", valid_x, 0);
    check("async_valid_m", valid_m, 0);
    check("async_rd_x", rd_x, 0);
    check("async_rd_m", rd_m, 0);
    #2;
    rst = 1'b0;
    drive(I_LUI_X7, 1'b1, 1'b0, 1'b0);
    step();
    check("post_rst_ctrl_x", ctrl_x, 16'h1547);
    check("post_rst_rd_x", rd_x, 7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
